// File: rtl/simon_serial_pkg.sv
// rtl/simon_serial_pkg.sv - shared types and constants for the Simon64/96 serial host driver
package simon_serial_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_PT  = 3'd1,
      LOAD_KEY = 3'd2,
      RUN      = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Mode values presented on the core's data_rdy input
   localparam logic [1:0] RDY_IDLE = 2'd0;
   localparam logic [1:0] RDY_PT   = 2'd1;
   localparam logic [1:0] RDY_KEY  = 2'd2;
   localparam logic [1:0] RDY_RUN  = 2'd3;

   localparam int DEF_BLOCK_BITS = 64;
   localparam int DEF_KEY_BITS   = 96;
   localparam int DEF_RUN_CYCLES = 2688;
   localparam int DEF_CAP_START  = 2624;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/simon_serial_shreg.sv
// rtl/simon_serial_shreg.sv - parallel-load shift register, shifts right (LSB out, serial_in at MSB)
module simon_serial_shreg #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data
);

   // Load has priority over shift; bit 0 is the next bit out, serial_in enters at the top
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift) begin
         data <= {serial_in, data[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/simon_serial_host_ctrl.sv
// rtl/simon_serial_host_ctrl.sv - sequences data_rdy and serialises PT/key into the Simon core, captures ciphertext
module simon_serial_host_ctrl
   import simon_serial_pkg::*;
#(
   parameter int BLOCK_BITS = DEF_BLOCK_BITS,
   parameter int KEY_BITS   = DEF_KEY_BITS,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int CAP_START  = DEF_CAP_START
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BLOCK_BITS-1:0] pt_in,
   input  logic [KEY_BITS-1:0]   key_in,
   output logic                  busy,
   output logic                  done,
   output logic [BLOCK_BITS-1:0] ct_out,
   output logic                  core_data_in,
   output logic [1:0]            core_data_rdy,
   input  logic                  core_cipher_out
);

   localparam int CNT_MAX = max_int(KEY_BITS, RUN_CYCLES);
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PT_LAST  = CW'(BLOCK_BITS - 1);
   localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BITS - 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
   localparam logic [CW-1:0] CAP_LO   = CW'(CAP_START);
   localparam logic [CW-1:0] CAP_HI   = CW'(CAP_START + BLOCK_BITS - 1);

   generate
      if (CAP_START + BLOCK_BITS > RUN_CYCLES) begin : g_bad_cap
         $error("capture window extends past the end of the run phase");
      end
   endgenerate

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [BLOCK_BITS-1:0] pt_q;
   logic [KEY_BITS-1:0]   key_q;
   logic [BLOCK_BITS-1:0] ct_q;
   logic [BLOCK_BITS-1:0] ct_next;
   logic                  accept;
   logic                  pt_shift;
   logic                  key_shift;
   logic                  cap_en;
   logic                  unused_taps;

   assign accept    = (state == IDLE) && start;
   assign pt_shift  = (state == LOAD_PT) && (cnt != PT_LAST);
   assign key_shift = ((state == LOAD_PT) && (cnt == PT_LAST)) ||
                      ((state == LOAD_KEY) && (cnt != KEY_LAST));
   assign cap_en    = (state == RUN) && (cnt >= CAP_LO) && (cnt <= CAP_HI);

   // Value the SIPO will hold after this edge, so the last window bit lands in ct_out
   assign ct_next   = cap_en ? {core_cipher_out, ct_q[BLOCK_BITS-1:1]} : ct_q;

   // PISO registers only feed bit 0 to the core; upper taps are intentionally dropped
   assign unused_taps = ^{pt_q[BLOCK_BITS-1:1], key_q[KEY_BITS-1:1]};

   // Bit 0 of the plaintext is driven straight from pt_in at accept, so the register holds bits 1..N-1
   simon_serial_shreg #(.WIDTH(BLOCK_BITS)) u_pt_sr (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_data ({1'b0, pt_in[BLOCK_BITS-1:1]}),
      .shift     (pt_shift),
      .serial_in (1'b0),
      .data      (pt_q)
   );

   simon_serial_shreg #(.WIDTH(KEY_BITS)) u_key_sr (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_data (key_in),
      .shift     (key_shift),
      .serial_in (1'b0),
      .data      (key_q)
   );

   simon_serial_shreg #(.WIDTH(BLOCK_BITS)) u_ct_sr (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ('0),
      .shift     (cap_en),
      .serial_in (core_cipher_out),
      .data      (ct_q)
   );

   // Phase sequencer: outputs are set one edge ahead so they line up with the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ct_out        <= '0;
         core_data_in  <= 1'b0;
         core_data_rdy <= RDY_IDLE;
      end else begin
         case (state)
            IDLE: begin
               done          <= 1'b0;
               core_data_in  <= 1'b0;
               core_data_rdy <= RDY_IDLE;
               cnt           <= '0;
               if (start) begin
                  state         <= LOAD_PT;
                  busy          <= 1'b1;
                  core_data_rdy <= RDY_PT;
                  core_data_in  <= pt_in[0];
               end
            end
            LOAD_PT: begin
               if (cnt == PT_LAST) begin
                  state         <= LOAD_KEY;
                  cnt           <= '0;
                  core_data_rdy <= RDY_KEY;
                  core_data_in  <= key_q[0];
               end else begin
                  cnt          <= cnt + CW'(1);
                  core_data_in <= pt_q[0];
               end
            end
            LOAD_KEY: begin
               if (cnt == KEY_LAST) begin
                  state         <= RUN;
                  cnt           <= '0;
                  core_data_rdy <= RDY_RUN;
                  core_data_in  <= 1'b0;
               end else begin
                  cnt          <= cnt + CW'(1);
                  core_data_in <= key_q[0];
               end
            end
            RUN: begin
               if (cnt == RUN_LAST) begin
                  state         <= DONE;
                  cnt           <= '0;
                  core_data_rdy <= RDY_IDLE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  ct_out        <= ct_next;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
               done  <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               cnt           <= '0;
               busy          <= 1'b0;
               done          <= 1'b0;
               core_data_in  <= 1'b0;
               core_data_rdy <= RDY_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_serial_host_ctrl.sv
// tb/tb_simon_serial_host_ctrl.sv - directed bench with a stub core that echoes loaded data as ciphertext
module tb_simon_serial_host_ctrl;

   localparam int BB = 64;
   localparam int KB = 96;
   localparam int RC = 2688;
   localparam int CS = 2624;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [BB-1:0] pt_in;
   logic [KB-1:0] key_in;
   logic          busy;
   logic          done;
   logic [BB-1:0] ct_out;
   logic          core_data_in;
   logic [1:0]    core_data_rdy;
   logic          core_cipher_out;

   simon_serial_host_ctrl #(
      .BLOCK_BITS (BB),
      .KEY_BITS   (KB),
      .RUN_CYCLES (RC),
      .CAP_START  (CS)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .pt_in           (pt_in),
      .key_in          (key_in),
      .busy            (busy),
      .done            (done),
      .ct_out          (ct_out),
      .core_data_in    (core_data_in),
      .core_data_rdy   (core_data_rdy),
      .core_cipher_out (core_cipher_out)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Stub core: records what is shifted in per phase and plays back pt ^ key[95:32] in the window
   logic          stub_clr  = 1'b0;
   int            stub_mode = 0;
   logic [BB-1:0] pt_seen   = '0;
   logic [KB-1:0] key_seen  = '0;
   int            pt_cnt = 0, key_cnt = 0, run_cnt = 0, run_ones = 0, run_idx = 0;
   int            bad_order = 0;
   logic [1:0]    prev_rdy = 2'd0;
   logic [1:0]    rdy_succ;
   logic [BB-1:0] src;

   assign rdy_succ = prev_rdy + 2'd1;
   assign src      = pt_seen ^ key_seen[95:32];

   // Observe the serial interface the way the core would
   always @(posedge clk) begin
      prev_rdy <= core_data_rdy;
      if (core_data_rdy != prev_rdy && core_data_rdy != rdy_succ) bad_order <= bad_order + 1;
      run_idx <= (core_data_rdy == 2'd3) ? run_idx + 1 : 0;
      if (stub_clr) begin
         pt_cnt <= 0; key_cnt <= 0; run_cnt <= 0; run_ones <= 0;
         pt_seen <= '0; key_seen <= '0;
      end else begin
         case (core_data_rdy)
            2'd1: begin
               if (pt_cnt < BB) pt_seen[pt_cnt] <= core_data_in;
               pt_cnt <= pt_cnt + 1;
            end
            2'd2: begin
               if (key_cnt < KB) key_seen[key_cnt] <= core_data_in;
               key_cnt <= key_cnt + 1;
            end
            2'd3: begin
               run_cnt <= run_cnt + 1;
               if (core_data_in) run_ones <= run_ones + 1;
            end
            default: ;
         endcase
      end
   end

   // Ciphertext bit from the stub; 1 outside the window so a shifted window corrupts the result
   always_comb begin
      core_cipher_out = 1'b1;
      if (stub_mode == 1) begin
         core_cipher_out = (core_data_rdy == 2'd3) && (run_idx == CS + 5);
      end else if (core_data_rdy == 2'd3 && run_idx >= CS && run_idx < CS + BB) begin
         core_cipher_out = src[6'(run_idx - CS)];
      end
   end

   typedef struct {
      logic [BB-1:0] pt;
      logic [KB-1:0] key;
      int            mode;
      logic [BB-1:0] exp_ct;
   } vec_t;

   vec_t          vecs[5];
   logic [BB-1:0] last_ct = '0;

   task automatic run_op(input logic [BB-1:0] pt, input logic [KB-1:0] key, input int mode,
                         input logic [BB-1:0] exp_ct, input string tag);
      int n;
      int hold_bad;
      hold_bad = 0;
      @(negedge clk);
      check({tag, " ct_hold"}, ct_out, last_ct);
      stub_mode = mode; pt_in = pt; key_in = key; start = 1'b1; stub_clr = 1'b1;
      @(negedge clk);
      start = 1'b0; stub_clr = 1'b0;
      pt_in = ~pt; key_in = ~key;
      check({tag, " busy"}, busy, 1);
      check({tag, " rdy_pt"}, core_data_rdy, 1);
      check({tag, " first_bit"}, core_data_in, pt[0]);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!done && ct_out !== last_ct) hold_bad++;
      end while (!done && n < 4000);
      check({tag, " latency"}, n + 2, 2850);
      check({tag, " ct_out"}, ct_out, exp_ct);
      check({tag, " done_busy"}, busy, 0);
      check({tag, " done_rdy"}, core_data_rdy, 0);
      check({tag, " ct_stable"}, hold_bad, 0);
      check({tag, " pt_seen"}, pt_seen, pt);
      check({tag, " key_seen"}, key_seen, key);
      check({tag, " pt_cycles"}, pt_cnt, BB);
      check({tag, " key_cycles"}, key_cnt, KB);
      check({tag, " run_cycles"}, run_cnt, RC);
      check({tag, " run_data_in"}, run_ones, 0);
      @(negedge clk);
      check({tag, " done_pulse"}, done, 0);
      check({tag, " idle_rdy"}, core_data_rdy, 0);
      last_ct = exp_ct;
   endtask

   initial begin
      int n;
      int dones;
      vecs[0] = '{64'h0000000000000001, 96'h000000000000000000000001, 0, 64'h0000000000000001};
      vecs[1] = '{64'h6f7220676e696c63, 96'h131211100b0a090803020100, 0, 64'h7c6031776563656b};
      vecs[2] = '{64'hffffffff00000000, 96'h000000000000000000000000, 0, 64'hffffffff00000000};
      vecs[3] = '{64'h0000000000000000, 96'ha5a5a5a55a5a5a5a0f0f0f0f, 0, 64'ha5a5a5a55a5a5a5a};
      vecs[4] = '{64'h6f7220676e696c63, 96'h131211100b0a090803020100, 1, 64'h0000000000000020};

      rst = 1'b1; start = 1'b0; pt_in = '0; key_in = '0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset ct_out", ct_out, 0);
      check("reset data_in", core_data_in, 0);
      check("reset rdy", core_data_rdy, 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].pt, vecs[i].key, vecs[i].mode, vecs[i].exp_ct, $sformatf("vec%0d", i));
      end

      // Reset in the middle of the run phase
      @(negedge clk);
      stub_mode = 0; pt_in = 64'h1122334455667788; key_in = 96'h1; start = 1'b1; stub_clr = 1'b1;
      @(negedge clk);
      start = 1'b0; stub_clr = 1'b0;
      n = 0;
      while (!(core_data_rdy == 2'd3 && run_idx >= 100) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("rst reached_run", core_data_rdy, 3);
      rst = 1'b1;
      @(negedge clk);
      check("rst rdy", core_data_rdy, 0);
      check("rst busy", busy, 0);
      check("rst ct_out", ct_out, 0);
      check("rst done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("rst no_done", dones, 0);
      check("rst idle_rdy", core_data_rdy, 0);
      last_ct = '0;

      // start held high across a whole run with pt_in toggling; second op begins right after DONE
      @(negedge clk);
      stub_mode = 0; pt_in = 64'h0123456789abcdef; key_in = 96'h000000000000000100000000;
      start = 1'b1; stub_clr = 1'b1;
      @(negedge clk);
      stub_clr = 1'b0;
      n = 0;
      do begin
         pt_in = ~pt_in;
         @(negedge clk);
         n++;
      end while (!done && n < 4000);
      check("held latency", n + 1, 2849);
      check("held ct_out", ct_out, 64'h0123456789abcdee);
      pt_in = 64'hfedcba9876543210;
      stub_clr = 1'b1;
      @(negedge clk);
      stub_clr = 1'b0;
      check("held gap_done", done, 0);
      check("held gap_rdy", core_data_rdy, 0);
      @(negedge clk);
      check("held restart_rdy", core_data_rdy, 1);
      check("held restart_busy", busy, 1);
      check("held restart_bit", core_data_in, 0);
      start = 1'b0;
      n = 0;
      dones = 0;
      do begin
         @(negedge clk);
         n++;
         if (done) dones++;
      end while (!done && n < 4000);
      check("held2 latency", n + 1, 2849);
      check("held2 ct_out", ct_out, 64'hfedcba9876543211);
      check("held2 pt_seen", pt_seen, 64'hfedcba9876543210);
      @(negedge clk);
      check("held2 single_done", done, 0);
      check("rdy order", bad_order, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
